// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types and constants for the branch resolution controller.
// Holds the predictor queue entry layout, FSM encoding and the redirect helper.
package branch_resolve_ctrl_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] DELAY_SLOT_OFFSET = 32'd8;

  typedef enum logic [1:0] {
    OP_BEQ  = 2'd0,
    OP_BNE  = 2'd1,
    OP_BGTZ = 2'd2,
    OP_BLEZ = 2'd3
  } br_op_t;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            taken;
    logic [XLEN-1:0] target;
  } pred_entry_t;

  localparam int unsigned PRED_ENTRY_W = $bits(pred_entry_t);

  // Correct fetch address: taken target, or fall-through past the delay slot.
  function automatic logic [XLEN-1:0] fix_pc(input logic taken,
                                             input logic [XLEN-1:0] target,
                                             input logic [XLEN-1:0] pc);
    return taken ? target : pc + DELAY_SLOT_OFFSET;
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_pred_fifo.sv
// In-order queue of in-flight predictions: circular buffer with occupancy count.
// Synchronous clear drops every entry at once (wrong-path squash).
module pred_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 65
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: tracks decode-time predictions, checks them in EX,
// trains the predictor and drives flush/redirect on a mispredict.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned FLUSH_CYC = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_valid,
  input  logic [XLEN-1:0]          push_pc,
  input  logic                     push_taken,
  input  logic [XLEN-1:0]          push_target,
  output logic                     push_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic [XLEN-1:0]          res_target,
  output logic                     flush,
  output logic [XLEN-1:0]          redirect_pc,
  output logic                     upd_valid,
  output logic [XLEN-1:0]          upd_pc,
  output logic                     upd_taken,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic [CNT_W-1:0]         mispredict_cnt,
  output logic                     err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned FW = 4;

  state_t      state;
  state_t      state_d;
  logic [FW-1:0] fcnt;
  logic [FW-1:0] fcnt_d;

  pred_entry_t head;
  pred_entry_t push_entry;
  logic [PRED_ENTRY_W-1:0] head_raw;

  logic in_run;
  logic res_run;
  logic res_hit;
  logic mispredict;
  logic fifo_push;
  logic fifo_pop;
  logic fifo_clear;

  logic                flush_d;
  logic [XLEN-1:0]     redirect_d;
  logic                upd_valid_d;
  logic [XLEN-1:0]     upd_pc_d;
  logic                upd_taken_d;
  logic [CNT_W-1:0]    mcnt_d;
  logic                err_d;

  assign push_entry = '{pc: push_pc, taken: push_taken, target: push_target};
  assign head       = pred_entry_t'(head_raw);

  // Resolve qualification and mispredict detection against the oldest entry.
  assign in_run     = (state == ST_RUN);
  assign res_run    = res_valid && in_run;
  assign res_hit    = res_run && (inflight != '0);
  assign mispredict = res_hit &&
                      ((res_taken != head.taken) ||
                       (res_taken && (res_target != head.target)));
  assign fifo_pop   = res_hit && !mispredict;
  assign fifo_clear = mispredict;
  // A full queue still takes a push when a correct resolve frees the head slot.
  assign fifo_push  = push_valid && in_run && !mispredict &&
                      ((inflight < CW'(DEPTH)) || fifo_pop);

  assign push_ready = (inflight < CW'(DEPTH)) && in_run;

  pred_fifo #(
    .DEPTH (DEPTH),
    .W     (PRED_ENTRY_W)
  ) u_pred_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (fifo_clear),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (head_raw),
    .count     (inflight)
  );

  // State register with flush-window down-counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
      fcnt  <= '0;
    end else begin
      state <= state_d;
      fcnt  <= fcnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    fcnt_d  = fcnt;
    case (state)
      ST_RUN: begin
        if (mispredict) begin
          state_d = ST_RECOVER;
          fcnt_d  = FW'(FLUSH_CYC - 1);
        end
      end
      ST_RECOVER: begin
        if (fcnt == '0) state_d = ST_RUN;
        else            fcnt_d  = fcnt - FW'(1);
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Next values for the registered outputs.
  always_comb begin
    flush_d     = (state_d == ST_RECOVER);
    redirect_d  = redirect_pc;
    upd_valid_d = res_hit;
    upd_pc_d    = upd_pc;
    upd_taken_d = upd_taken;
    mcnt_d      = mispredict_cnt;
    err_d       = err || (res_run && (inflight == '0));
    if (res_hit) begin
      upd_pc_d    = head.pc;
      upd_taken_d = res_taken;
    end
    if (mispredict) begin
      redirect_d = fix_pc(res_taken, res_target, head.pc);
      if (mispredict_cnt != {CNT_W{1'b1}}) mcnt_d = mispredict_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush          <= 1'b0;
      redirect_pc    <= '0;
      upd_valid      <= 1'b0;
      upd_pc         <= '0;
      upd_taken      <= 1'b0;
      mispredict_cnt <= '0;
      err            <= 1'b0;
    end else begin
      flush          <= flush_d;
      redirect_pc    <= redirect_d;
      upd_valid      <= upd_valid_d;
      upd_pc         <= upd_pc_d;
      upd_taken      <= upd_taken_d;
      mispredict_cnt <= mcnt_d;
      err            <= err_d;
    end
  end

endmodule
